mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 100 ++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a small register bank. Each transaction walks
// IDLE -> SERVE -> RESP; a round-robin pointer decides simultaneous requests.
module mem_arbiter #(
    parameter int N_CELLS = 4,
    parameter int WIDTH   = 2,
    localparam int AW     = $clog2(N_CELLS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_a,
    input  logic             req_b,
    input  logic             we_a,
    input  logic             we_b,
    input  logic [AW-1:0]    addr_a,
    input  logic [AW-1:0]    addr_b,
    input  logic [WIDTH-1:0] wdata_a,
    input  logic [WIDTH-1:0] wdata_b,
    output logic             ack_a,
    output logic             ack_b,
    output logic [WIDTH-1:0] rdata_a,
    output logic [WIDTH-1:0] rdata_b,
    output logic             busy,
    output logic             owner
);

    typedef enum logic [1:0] {IDLE, SERVE, RESP} state_t;

    state_t           state, state_nx;
    logic             rr;
    logic             win;
    logic             lat_we;
    logic [AW-1:0]    lat_addr;
    logic [WIDTH-1:0] lat_wdata;
    logic [WIDTH-1:0] bank [N_CELLS];

    // A lone request wins outright; a tie goes to the round-robin pointer
    assign win = (req_a && req_b) ? rr : req_b;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state: SERVE and RESP are fixed single-cycle steps
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (req_a || req_b) state_nx = SERVE;
            SERVE:   state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs decoded from state and the current owner
    always_comb begin
        busy  = (state != IDLE);
        ack_a = (state == RESP) && !owner;
        ack_b = (state == RESP) &&  owner;
    end

    // Grant: capture the winner's command so later input changes cannot leak in
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner     <= 1'b0;
            rr        <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if (state == IDLE && (req_a || req_b)) begin
            owner     <= win;
            rr        <= ~win;
            lat_we    <= win ? we_b    : we_a;
            lat_addr  <= win ? addr_b  : addr_a;
            lat_wdata <= win ? wdata_b : wdata_a;
        end
    end

    // Bank write on the SERVE-exit edge; reset clears every cell
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CELLS; i++) bank[i] <= '0;
        end else if (state == SERVE && lat_we) begin
            bank[lat_addr] <= lat_wdata;
        end
    end

    // Read result lands only in the owner's rdata and is held until its next read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_a <= '0;
            rdata_b <= '0;
        end else if (state == SERVE && !lat_we) begin
            if (owner) rdata_b <= bank[lat_addr];
            else       rdata_a <= bank[lat_addr];
        end
    end

endmodule
